// File: rtl/time_base_ctrl.sv
`default_nettype none
// ==========================================================================
// time_base_ctrl : shadowed TIC/ACCUM divisors, TIC counter, flags, snapshots
// Revision 1.0
// ==========================================================================
module time_base_ctrl #(
  parameter logic [23:0] TIC_DIV_RST   = 24'h3D08FF,
  parameter logic [23:0] ACCUM_DIV_RST = 24'h004E1F
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        wr_en,
  input  logic [2:0]  wr_addr,
  input  logic [31:0] wr_data,
  input  logic        rd_en,
  input  logic [2:0]  rd_addr,
  output logic [31:0] rd_data,
  input  logic        pre_tic_enable,
  input  logic        tic_enable,
  input  logic        accum_enable,
  input  logic [23:0] tic_count,
  input  logic [23:0] accum_count,
  output logic [23:0] tic_divide,
  output logic [23:0] accum_divide,
  output logic        tic_int,
  output logic        accum_int
);

  localparam logic [2:0] c_addr_tic_sh   = 3'd0;
  localparam logic [2:0] c_addr_accum_sh = 3'd1;
  localparam logic [2:0] c_addr_ctrl     = 3'd2;
  localparam logic [2:0] c_addr_status   = 3'd3;
  localparam logic [2:0] c_addr_tic_num  = 3'd4;
  localparam logic [2:0] c_addr_snap_tic = 3'd5;
  localparam logic [2:0] c_addr_snap_acc = 3'd6;
  localparam logic [2:0] c_addr_snap     = 3'd7;

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PENDING = 1'b1
  } upd_state_t;

  upd_state_t  tic_st_q, tic_st_d, accum_st_q, accum_st_d;
  logic [23:0] tic_shadow_q, tic_shadow_d, accum_shadow_q, accum_shadow_d;
  logic [23:0] tic_divide_q, tic_divide_d, accum_divide_q, accum_divide_d;
  logic [23:0] snap_tic_q, snap_tic_d, snap_accum_q, snap_accum_d;
  logic        tic_int_en_q, tic_int_en_d, accum_int_en_q, accum_int_en_d;
  logic        tic_flag_q, tic_flag_d, accum_flag_q, accum_flag_d;
  logic        tic_ovr_q, tic_ovr_d, accum_ovr_q, accum_ovr_d;
  logic [31:0] tic_number_q, tic_number_d;
  logic [31:0] rd_data_q, rd_data_d;

  logic        w_wr_ctrl;
  logic        w_status_rd;
  logic [31:0] w_rd_mux;
  logic        w_unused;

  assign w_wr_ctrl   = wr_en && (wr_addr == c_addr_ctrl);
  assign w_status_rd = rd_en && (rd_addr == c_addr_status);
  assign w_unused    = ^wr_data[30:24];

  // Read mux samples pre-edge state, so a same-cycle write or clear returns the old value
  always_comb begin
    w_rd_mux = '0;
    case (rd_addr)
      c_addr_tic_sh:   w_rd_mux[23:0] = tic_shadow_q;
      c_addr_accum_sh: w_rd_mux[23:0] = accum_shadow_q;
      c_addr_ctrl: begin
        w_rd_mux[3] = tic_int_en_q;
        w_rd_mux[2] = accum_int_en_q;
      end
      c_addr_status:   w_rd_mux[5:0] = {tic_ovr_q, accum_ovr_q,
                                        accum_st_q == ST_PENDING,
                                        tic_st_q == ST_PENDING,
                                        tic_flag_q, accum_flag_q};
      c_addr_tic_num:  w_rd_mux = tic_number_q;
      c_addr_snap_tic: w_rd_mux[23:0] = snap_tic_q;
      c_addr_snap_acc: w_rd_mux[23:0] = snap_accum_q;
      default:         w_rd_mux = '0;
    endcase
  end

  always_comb begin
    tic_shadow_d   = tic_shadow_q;
    accum_shadow_d = accum_shadow_q;
    tic_int_en_d   = tic_int_en_q;
    accum_int_en_d = accum_int_en_q;
    snap_tic_d     = snap_tic_q;
    snap_accum_d   = snap_accum_q;
    if (wr_en) begin
      case (wr_addr)
        c_addr_tic_sh:   tic_shadow_d   = wr_data[23:0];
        c_addr_accum_sh: accum_shadow_d = wr_data[23:0];
        c_addr_ctrl: begin
          tic_int_en_d   = wr_data[3];
          accum_int_en_d = wr_data[2];
        end
        c_addr_snap: begin
          snap_tic_d   = tic_count;
          snap_accum_d = accum_count;
        end
        default: ;
      endcase
    end

    // Commit only on a boundary seen while already pending, using the pre-edge shadow
    tic_st_d     = tic_st_q;
    tic_divide_d = tic_divide_q;
    case (tic_st_q)
      ST_IDLE:    if (w_wr_ctrl && wr_data[0]) tic_st_d = ST_PENDING;
      ST_PENDING: if (pre_tic_enable) begin
        tic_divide_d = tic_shadow_q;
        tic_st_d     = ST_IDLE;
      end
      default:    tic_st_d = ST_IDLE;
    endcase

    accum_st_d     = accum_st_q;
    accum_divide_d = accum_divide_q;
    case (accum_st_q)
      ST_IDLE:    if (w_wr_ctrl && wr_data[1]) accum_st_d = ST_PENDING;
      ST_PENDING: if (accum_enable) begin
        accum_divide_d = accum_shadow_q;
        accum_st_d     = ST_IDLE;
      end
      default:    accum_st_d = ST_IDLE;
    endcase

    tic_flag_d   = tic_enable | (tic_flag_q & ~w_status_rd);
    accum_flag_d = accum_enable | (accum_flag_q & ~w_status_rd);
    tic_ovr_d    = ~w_status_rd & (tic_ovr_q | (tic_enable & tic_flag_q));
    accum_ovr_d  = ~w_status_rd & (accum_ovr_q | (accum_enable & accum_flag_q));

    if (w_wr_ctrl && wr_data[31]) begin
      tic_number_d = {31'd0, tic_enable};
    end else begin
      tic_number_d = tic_number_q + {31'd0, tic_enable};
    end

    rd_data_d = rd_en ? w_rd_mux : rd_data_q;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      tic_st_q       <= ST_IDLE;
      accum_st_q     <= ST_IDLE;
      tic_shadow_q   <= TIC_DIV_RST;
      accum_shadow_q <= ACCUM_DIV_RST;
      tic_divide_q   <= TIC_DIV_RST;
      accum_divide_q <= ACCUM_DIV_RST;
      snap_tic_q     <= '0;
      snap_accum_q   <= '0;
      tic_int_en_q   <= 1'b0;
      accum_int_en_q <= 1'b0;
      tic_flag_q     <= 1'b0;
      accum_flag_q   <= 1'b0;
      tic_ovr_q      <= 1'b0;
      accum_ovr_q    <= 1'b0;
      tic_number_q   <= '0;
      rd_data_q      <= '0;
    end else begin
      tic_st_q       <= tic_st_d;
      accum_st_q     <= accum_st_d;
      tic_shadow_q   <= tic_shadow_d;
      accum_shadow_q <= accum_shadow_d;
      tic_divide_q   <= tic_divide_d;
      accum_divide_q <= accum_divide_d;
      snap_tic_q     <= snap_tic_d;
      snap_accum_q   <= snap_accum_d;
      tic_int_en_q   <= tic_int_en_d;
      accum_int_en_q <= accum_int_en_d;
      tic_flag_q     <= tic_flag_d;
      accum_flag_q   <= accum_flag_d;
      tic_ovr_q      <= tic_ovr_d;
      accum_ovr_q    <= accum_ovr_d;
      tic_number_q   <= tic_number_d;
      rd_data_q      <= rd_data_d;
    end
  end

  assign rd_data      = rd_data_q;
  assign tic_divide   = tic_divide_q;
  assign accum_divide = accum_divide_q;
  assign tic_int      = tic_flag_q & tic_int_en_q;
  assign accum_int    = accum_flag_q & accum_int_en_q;

endmodule
`default_nettype wire

// File: tb/tb_time_base_ctrl.sv
`default_nettype none
// ==========================================================================
// tb_time_base_ctrl : vector table, corner sequences and randomized run
// Revision 1.0
// ==========================================================================
module tb_time_base_ctrl;

  logic        clk = 1'b0;
  logic        rstn;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rd_en;
  logic [2:0]  rd_addr;
  logic [31:0] rd_data;
  logic        pre_tic_enable;
  logic        tic_enable;
  logic        accum_enable;
  logic [23:0] tic_count;
  logic [23:0] accum_count;
  logic [23:0] tic_divide;
  logic [23:0] accum_divide;
  logic        tic_int;
  logic        accum_int;

  time_base_ctrl dut (
    .clk(clk), .rstn(rstn),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pre_tic_enable(pre_tic_enable), .tic_enable(tic_enable),
    .accum_enable(accum_enable), .tic_count(tic_count), .accum_count(accum_count),
    .tic_divide(tic_divide), .accum_divide(accum_divide),
    .tic_int(tic_int), .accum_int(accum_int)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model; index 0 = TIC divider, 1 = ACCUM divider
  logic [23:0] m_sh [2];
  logic [23:0] m_div[2];
  bit          m_pend[2];
  bit          m_flag[2];
  bit          m_ovr [2];
  bit          m_en  [2];
  logic [23:0] m_snap[2];
  logic [31:0] m_num;
  logic [31:0] m_rd;

  // Bench-side time base: period = divisor + 1, reload with the pre-edge divisor
  bit          tb_auto = 1'b0;
  int          tb_cnt  = 0;
  bit          tb_pre_d = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_sh[0] = 24'h3D08FF; m_sh[1] = 24'h004E1F;
    m_div[0] = 24'h3D08FF; m_div[1] = 24'h004E1F;
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 0; m_flag[k] = 0; m_ovr[k] = 0; m_en[k] = 0; m_snap[k] = '0;
    end
    m_num = '0;
    m_rd  = '0;
  endtask

  function automatic logic [31:0] m_read(input logic [2:0] a);
    logic [31:0] v;
    v = '0;
    case (a)
      3'd0: v = {8'd0, m_sh[0]};
      3'd1: v = {8'd0, m_sh[1]};
      3'd2: v = (32'(m_en[0]) << 3) | (32'(m_en[1]) << 2);
      3'd3: v = 32'(m_flag[1]) | (32'(m_flag[0]) << 1) | (32'(m_pend[0]) << 2) |
                (32'(m_pend[1]) << 3) | (32'(m_ovr[1]) << 4) | (32'(m_ovr[0]) << 5);
      3'd4: v = m_num;
      3'd5: v = {8'd0, m_snap[0]};
      3'd6: v = {8'd0, m_snap[1]};
      default: v = '0;
    endcase
    return v;
  endfunction

  task automatic model_edge();
    bit rclr;
    bit bnd[2];
    bit ev[2];
    if (!rstn) begin
      model_reset();
      return;
    end
    if (rd_en) m_rd = m_read(rd_addr);
    rclr = rd_en && (rd_addr == 3'd3);
    bnd[0] = pre_tic_enable; bnd[1] = accum_enable;
    ev[0]  = tic_enable;     ev[1]  = accum_enable;
    for (int k = 0; k < 2; k++) begin
      if (m_pend[k] && bnd[k]) begin
        m_div[k]  = m_sh[k];
        m_pend[k] = 0;
      end else if (wr_en && wr_addr == 3'd2 && wr_data[k]) begin
        m_pend[k] = 1;
      end
      m_ovr[k]  = !rclr && (m_ovr[k] || (ev[k] && m_flag[k]));
      m_flag[k] = ev[k] || (m_flag[k] && !rclr);
    end
    if (wr_en && wr_addr == 3'd2 && wr_data[31]) m_num = 32'(ev[0]);
    else                                          m_num = m_num + 32'(ev[0]);
    if (wr_en) begin
      case (wr_addr)
        3'd0: m_sh[0] = wr_data[23:0];
        3'd1: m_sh[1] = wr_data[23:0];
        3'd2: begin m_en[0] = wr_data[3]; m_en[1] = wr_data[2]; end
        3'd7: begin m_snap[0] = tic_count; m_snap[1] = accum_count; end
        default: ;
      endcase
    end
  endtask

  task automatic check_model();
    chk("model_rd_data", rd_data, m_rd);
    chk("model_tic_divide", {8'd0, tic_divide}, {8'd0, m_div[0]});
    chk("model_accum_divide", {8'd0, accum_divide}, {8'd0, m_div[1]});
    chk("model_tic_int", {31'd0, tic_int}, {31'd0, m_flag[0] & m_en[0]});
    chk("model_accum_int", {31'd0, accum_int}, {31'd0, m_flag[1] & m_en[1]});
  endtask

  task automatic step();
    logic [23:0] old_div;
    if (tb_auto) begin
      pre_tic_enable = (tb_cnt == 0);
      tic_enable     = tb_pre_d;
      tic_count      = 24'(tb_cnt);
    end
    old_div = tic_divide;
    model_edge();
    @(posedge clk);
    #1;
    if (tb_auto) begin
      tb_pre_d = pre_tic_enable;
      tb_cnt   = (tb_cnt == 0) ? int'(old_div) : tb_cnt - 1;
    end
    check_model();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    step();
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
    rd_en = 1'b1; rd_addr = a;
    step();
    rd_en = 1'b0;
    chk(name, rd_data, exp);
  endtask

  typedef struct packed {
    bit          wr;
    logic [2:0]  waddr;
    logic [31:0] wdata;
    bit          rd;
    logic [2:0]  raddr;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[16];
  int   t_tic[3];
  int   nt;
  bit   prev_pre;

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd0, 32'h003D08FF};
    vecs[1]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd1, 32'h00004E1F};
    vecs[2]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd2, 32'h0};
    vecs[3]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd3, 32'h0};
    vecs[4]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd4, 32'h0};
    vecs[5]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd5, 32'h0};
    vecs[6]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd6, 32'h0};
    vecs[7]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd7, 32'h0};
    vecs[8]  = '{1'b1, 3'd2, 32'h0000000C, 1'b1, 3'd2, 32'h0};
    vecs[9]  = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd2, 32'h0000000C};
    vecs[10] = '{1'b1, 3'd0, 32'hFF000063, 1'b1, 3'd0, 32'h003D08FF};
    vecs[11] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd0, 32'h00000063};
    vecs[12] = '{1'b1, 3'd4, 32'h00000055, 1'b1, 3'd4, 32'h0};
    vecs[13] = '{1'b1, 3'd2, 32'h0000000F, 1'b1, 3'd3, 32'h0};
    vecs[14] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd3, 32'h0000000C};
    vecs[15] = '{1'b0, 3'd0, 32'h0,        1'b1, 3'd2, 32'h0000000C};

    rstn = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_en = 1'b0; rd_addr = '0;
    pre_tic_enable = 1'b0; tic_enable = 1'b0; accum_enable = 1'b0;
    tic_count = '0; accum_count = '0;
    model_reset();
    step();
    step();
    rstn = 1'b1;
    chk("reset_tic_divide", {8'd0, tic_divide}, 32'h003D08FF);
    chk("reset_accum_divide", {8'd0, accum_divide}, 32'h00004E1F);
    chk("reset_ints", {30'd0, tic_int, accum_int}, 32'h0);

    for (int i = 0; i < 16; i++) begin
      wr_en = vecs[i].wr; wr_addr = vecs[i].waddr; wr_data = vecs[i].wdata;
      rd_en = vecs[i].rd; rd_addr = vecs[i].raddr;
      step();
      if (vecs[i].rd) chk($sformatf("vec%0d_rd", i), rd_data, vecs[i].exp);
    end
    wr_en = 1'b0; rd_en = 1'b0;

    // TIC commit waits for the boundary
    step(); step(); step();
    chk("tic_div_hold", {8'd0, tic_divide}, 32'h003D08FF);
    pre_tic_enable = 1'b1; step(); pre_tic_enable = 1'b0;
    chk("tic_commit", {8'd0, tic_divide}, 32'h00000063);
    tic_enable = 1'b1; step(); tic_enable = 1'b0;
    chk("tic_int_set", {31'd0, tic_int}, 32'h1);
    rd(3'd3, "status_tic_flag", 32'h0000000A);
    rd(3'd3, "status_after_clear", 32'h00000008);
    chk("tic_int_drop", {31'd0, tic_int}, 32'h0);

    // Accum flag, overrun, read-to-clear, coincident set
    accum_enable = 1'b1; step(); step(); accum_enable = 1'b0;
    chk("accum_int_set", {31'd0, accum_int}, 32'h1);
    rd(3'd3, "status_accum_ovr", 32'h00000011);
    rd(3'd3, "status_accum_clr", 32'h0);
    chk("accum_int_drop", {31'd0, accum_int}, 32'h0);
    accum_enable = 1'b1; step();
    rd_en = 1'b1; rd_addr = 3'd3; step(); rd_en = 1'b0; accum_enable = 1'b0;
    chk("status_coincident_read", rd_data, 32'h00000001);
    rd(3'd3, "status_set_wins", 32'h00000001);

    // Request on the boundary cycle defers; shadow rewrite while pending
    wr(3'd0, 32'h20);
    pre_tic_enable = 1'b1; wr(3'd2, 32'h0D); pre_tic_enable = 1'b0;
    chk("req_at_boundary_no_commit", {8'd0, tic_divide}, 32'h00000063);
    wr(3'd0, 32'h31);
    pre_tic_enable = 1'b1; step(); pre_tic_enable = 1'b0;
    chk("shadow_rewrite_commit", {8'd0, tic_divide}, 32'h00000031);

    // Live time base: old period completes, new spacing starts one period later
    wr(3'd0, 32'h63);
    wr(3'd2, 32'h0D);
    tb_cnt = 5; tb_pre_d = 1'b0; tb_auto = 1'b1;
    nt = 0;
    for (int c = 0; c < 400 && nt < 3; c++) begin
      step();
      if (tic_enable) begin
        t_tic[nt] = c;
        nt++;
      end
    end
    tb_auto = 1'b0; pre_tic_enable = 1'b0; tic_enable = 1'b0;
    step();
    chk("tic_pulses_seen", nt, 3);
    chk("tic_spacing_old", t_tic[1] - t_tic[0], 50);
    chk("tic_spacing_new", t_tic[2] - t_tic[1], 100);
    chk("tic_divide_live", {8'd0, tic_divide}, 32'h00000063);

    // TIC_NUMBER clear, wrap, clear with coincident tic
    wr(3'd2, 32'h8000000C);
    rd(3'd4, "tic_number_cleared", 32'h0);
    force dut.tic_number_q = 32'hFFFFFFFF;
    #2;
    release dut.tic_number_q;
    m_num = 32'hFFFFFFFF;
    tic_enable = 1'b1; step(); tic_enable = 1'b0;
    rd(3'd4, "tic_number_wrap", 32'h0);
    tic_enable = 1'b1; wr(3'd2, 32'h8000000C); tic_enable = 1'b0;
    rd(3'd4, "tic_number_clear_plus_tic", 32'h1);

    // Snapshot latch
    tic_count = 24'h123456; accum_count = 24'h00ABCD;
    wr(3'd7, 32'h0);
    tic_count = 24'h0; accum_count = 24'h0;
    rd(3'd5, "snap_tic", 32'h00123456);
    rd(3'd6, "snap_accum", 32'h0000ABCD);
    rd(3'd7, "snap_strobe_reads_0", 32'h0);

    // Reset while both updates pending
    rd_en = 1'b1; rd_addr = 3'd3; step(); rd_en = 1'b0;
    wr(3'd0, 32'h10);
    wr(3'd2, 32'h03);
    rd(3'd3, "pending_before_reset", 32'h0000000C);
    rstn = 1'b0; step(); rstn = 1'b1;
    chk("reset_tic_div_default", {8'd0, tic_divide}, 32'h003D08FF);
    chk("reset_accum_div_default", {8'd0, accum_divide}, 32'h00004E1F);
    rd(3'd3, "pending_after_reset", 32'h0);
    pre_tic_enable = 1'b1; step(); pre_tic_enable = 1'b0;
    chk("no_commit_after_reset", {8'd0, tic_divide}, 32'h003D08FF);

    // Randomized traffic against the model
    prev_pre = 1'b0;
    for (int c = 0; c < 800; c++) begin
      rstn           = ($urandom_range(0, 99) != 0);
      pre_tic_enable = ($urandom_range(0, 7) == 0);
      tic_enable     = prev_pre;
      prev_pre       = pre_tic_enable;
      accum_enable   = ($urandom_range(0, 5) == 0);
      wr_en          = ($urandom_range(0, 2) == 0);
      wr_addr        = 3'($urandom_range(0, 7));
      wr_data        = $urandom;
      rd_en          = ($urandom_range(0, 1) == 0);
      rd_addr        = 3'($urandom_range(0, 7));
      tic_count      = 24'($urandom);
      accum_count    = 24'($urandom);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
